tex_sampler: RTL

- Downstream stage of the texture memory unit.
- Takes the four raw texels per lane fetched from the texture cache and unpacks each from its storage format to A8R8G8B8.
- In bilinear mode, blends the four texels with per-lane 8-bit fractional weights. In point mode, passes texel 0 through.
- 3-stage pipeline with valid/ready on both sides. Its output feeds the texture unit's response path back to the core.

---
 rtl/tex_sampler_if.sv | 35 +++
 rtl/tex_sampler.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/tex_sampler_if.sv
// Request/response bundle between the texture cache and the texture sampler.
// The sampler takes the slave view; whoever feeds it and drains it takes the master view.
interface tex_sampler_if #(
    parameter int NUM_LANES = 1,
    parameter int REQ_INFOW = 1
);
    logic                      req_valid;
    logic [NUM_LANES-1:0]      req_mask;
    logic                      req_filter;
    logic [2:0]                req_format;
    logic [NUM_LANES*2*8-1:0]  req_blends;
    logic [NUM_LANES*4*32-1:0] req_data;
    logic [REQ_INFOW-1:0]      req_info;
    logic                      req_ready;

    logic                      rsp_valid;
    logic [NUM_LANES-1:0]      rsp_mask;
    logic [NUM_LANES*32-1:0]   rsp_data;
    logic [REQ_INFOW-1:0]      rsp_info;
    logic                      rsp_ready;

    modport master (
        output req_valid, req_mask, req_filter, req_format, req_blends, req_data, req_info,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid, rsp_mask, rsp_data, rsp_info
    );

    modport slave (
        input  req_valid, req_mask, req_filter, req_format, req_blends, req_data, req_info,
        input  rsp_ready,
        output req_ready,
        output rsp_valid, rsp_mask, rsp_data, rsp_info
    );
endinterface

// File: rtl/tex_sampler.sv
// Texture sampler: unpacks four raw texels per lane to A8R8G8B8, then applies a
// bilinear blend (or passes texel 0 through in point mode) over a 3-stage valid/ready pipeline.
module tex_sampler #(
    parameter string INSTANCE_ID = "",
    parameter int    NUM_LANES   = 1,
    parameter int    REQ_INFOW   = 1
) (
    input logic          clk,
    input logic          reset,
    tex_sampler_if.slave bus
);

    // Narrow channels are widened by repeating their bits MSB-first, so full scale maps to 0xFF.
    function automatic logic [31:0] unpack_texel(input logic [2:0] fmt, input logic [31:0] raw);
        logic [31:0] px;
        px = '0;
        case (fmt)
            3'd0: px = raw;
            3'd1: px = {8'hFF, raw[15:11], raw[15:13], raw[10:5], raw[10:9], raw[4:0], raw[4:2]};
            3'd2: px = {{8{raw[15]}}, raw[14:10], raw[14:12], raw[9:5], raw[9:7], raw[4:0], raw[4:2]};
            3'd3: px = {{2{raw[15:12]}}, {2{raw[11:8]}}, {2{raw[7:4]}}, {2{raw[3:0]}}};
            3'd4: px = {raw[15:8], {3{raw[7:0]}}};
            3'd5: px = {8'hFF, {3{raw[7:0]}}};
            3'd6: px = {raw[7:0], 24'h000000};
            default: px = '0;
        endcase
        return px;
    endfunction

    function automatic logic [7:0] lerp8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
        logic [16:0] acc;
        acc = 17'(a) * (17'd256 - 17'(f)) + 17'(b) * 17'(f) + 17'd128;
        return 8'(acc >> 8);
    endfunction

    function automatic logic [31:0] lerp_px(input logic [31:0] a, input logic [31:0] b, input logic [7:0] f);
        logic [31:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            r[c*8 +: 8] = lerp8(a[c*8 +: 8], b[c*8 +: 8], f);
        return r;
    endfunction

    // The instance name only labels debug traces; it has no effect on the datapath.
    if (INSTANCE_ID == "") begin : g_anonymous
    end else begin : g_named
    end

    logic                      s1_valid, s2_valid, s3_valid;
    logic                      s1_ready, s2_ready, s3_ready;

    logic [NUM_LANES*4*32-1:0] unpacked, s1_texels;
    logic [NUM_LANES*16-1:0]   s1_blends;
    logic                      s1_filter;
    logic [NUM_LANES-1:0]      s1_mask;
    logic [REQ_INFOW-1:0]      s1_info;

    logic [NUM_LANES*32-1:0]   top_next, bot_next, s2_top, s2_bot;
    logic [NUM_LANES*8-1:0]    vfrac_next, s2_vfrac;
    logic                      s2_filter;
    logic [NUM_LANES-1:0]      s2_mask;
    logic [REQ_INFOW-1:0]      s2_info;

    logic [NUM_LANES*32-1:0]   out_next, s3_data;
    logic [NUM_LANES-1:0]      s3_mask;
    logic [REQ_INFOW-1:0]      s3_info;

    // Each stage accepts when empty or when its occupant leaves this cycle, so bubbles collapse.
    assign s3_ready      = ~s3_valid | bus.rsp_ready;
    assign s2_ready      = ~s2_valid | s3_ready;
    assign s1_ready      = ~s1_valid | s2_ready;
    assign bus.req_ready = s1_ready;

    assign bus.rsp_valid = s3_valid;
    assign bus.rsp_data  = s3_data;
    assign bus.rsp_mask  = s3_mask;
    assign bus.rsp_info  = s3_info;

    always_comb begin
        unpacked = '0;
        for (int i = 0; i < NUM_LANES*4; i++)
            unpacked[i*32 +: 32] = unpack_texel(bus.req_format, bus.req_data[i*32 +: 32]);
    end

    always_comb begin
        top_next   = '0;
        bot_next   = '0;
        vfrac_next = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (s1_filter) begin
                top_next[l*32 +: 32] = lerp_px(s1_texels[(l*4+0)*32 +: 32], s1_texels[(l*4+1)*32 +: 32],
                                               s1_blends[l*16 +: 8]);
                bot_next[l*32 +: 32] = lerp_px(s1_texels[(l*4+2)*32 +: 32], s1_texels[(l*4+3)*32 +: 32],
                                               s1_blends[l*16 +: 8]);
            end else begin
                top_next[l*32 +: 32] = s1_texels[(l*4)*32 +: 32];
                bot_next[l*32 +: 32] = s1_texels[(l*4)*32 +: 32];
            end
            vfrac_next[l*8 +: 8] = s1_blends[l*16+8 +: 8];
        end
    end

    always_comb begin
        out_next = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (s2_mask[l])
                out_next[l*32 +: 32] = s2_filter ? lerp_px(s2_top[l*32 +: 32], s2_bot[l*32 +: 32], s2_vfrac[l*8 +: 8])
                                                 : s2_top[l*32 +: 32];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid  <= 1'b0;
            s1_texels <= '0;
            s1_blends <= '0;
            s1_filter <= 1'b0;
            s1_mask   <= '0;
            s1_info   <= '0;
        end else if (s1_ready) begin
            s1_valid <= bus.req_valid;
            if (bus.req_valid) begin
                s1_texels <= unpacked;
                s1_blends <= bus.req_blends;
                s1_filter <= bus.req_filter;
                s1_mask   <= bus.req_mask;
                s1_info   <= bus.req_info;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid  <= 1'b0;
            s2_top    <= '0;
            s2_bot    <= '0;
            s2_vfrac  <= '0;
            s2_filter <= 1'b0;
            s2_mask   <= '0;
            s2_info   <= '0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_top    <= top_next;
                s2_bot    <= bot_next;
                s2_vfrac  <= vfrac_next;
                s2_filter <= s1_filter;
                s2_mask   <= s1_mask;
                s2_info   <= s1_info;
            end
        end
    end

    // Output registers hold steady while the consumer stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s3_valid <= 1'b0;
            s3_data  <= '0;
            s3_mask  <= '0;
            s3_info  <= '0;
        end else if (s3_ready) begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_data <= out_next;
                s3_mask <= s2_mask;
                s3_info <= s2_info;
            end
        end
    end

endmodule
